// File: rtl/sprite_line_engine.sv
// sprite_line_engine
// Scanline-buffered foreground renderer. While a line is displayed, the engine
// scans Object Memory for objects on the next line, then fetches their pattern
// rows into a preparation bank. At line_start the preparation bank becomes the
// active bank, and pixels are rendered from it with registered r/g/b/valid.
//
// Ports
//   i_clk_12_5875  pixel clock (posedge)
//   i_rst_n        synchronous active-low reset
//   i_line_start   one-cycle pulse at start of hblank
//   i_next_y       line to prepare, sampled on i_line_start
//   i_current_x    pixel column of the active line
//   o_obm_addr     OBM read index      / i_obm_data {x,y,attr,color_byte}, 1-cycle latency
//   o_pmf_addr     {pmfa,row}          / i_pmf_data pattern row, 1-cycle latency
//   o_r/o_g/o_b    foreground colour, o_valid opaque pixel present
//   o_overflow     displayed line had more hits than SLOTS
//   o_late         displayed line's preparation did not finish
module sprite_line_engine #(
    parameter int NUM_OBJECTS = 64,
    parameter int SLOTS       = 8
) (
    input  logic        i_clk_12_5875,
    input  logic        i_rst_n,
    input  logic        i_line_start,
    input  logic [7:0]  i_next_y,
    input  logic [7:0]  i_current_x,
    output logic [5:0]  o_obm_addr,
    input  logic [31:0] i_obm_data,
    output logic [7:0]  o_pmf_addr,
    input  logic [15:0] i_pmf_data,
    output logic [1:0]  o_r,
    output logic [1:0]  o_g,
    output logic [1:0]  o_b,
    output logic        o_valid,
    output logic        o_overflow,
    output logic        o_late
);
    localparam int CMAX = (NUM_OBJECTS > SLOTS) ? NUM_OBJECTS : SLOTS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;
    state_t r_state, w_nstate;

    logic [CW-1:0]         r_cnt;     // SCAN: issue index, FETCH: slot index
    logic [7:0]            r_y;
    logic [SW-1:0]         r_nfill;
    logic                  r_povf;

    // preparation bank
    logic [SLOTS-1:0][7:0]  r_px;
    logic [SLOTS-1:0][2:0]  r_pcol;
    logic [SLOTS-1:0]       r_phf;
    logic [SLOTS-1:0][2:0]  r_prow;
    logic [SLOTS-1:0][4:0]  r_ppmfa;
    logic [SLOTS-1:0][15:0] r_ppat;
    logic [SLOTS-1:0]       r_pfet;   // pattern row has arrived for this slot

    // active bank
    logic [SLOTS-1:0][7:0]  r_ax;
    logic [SLOTS-1:0][2:0]  r_acol;
    logic [SLOTS-1:0][15:0] r_apat;
    logic [SLOTS-1:0]       r_avld;

    logic [7:0] w_ox, w_oy, w_attr, w_ocb;
    assign {w_ox, w_oy, w_attr, w_ocb} = i_obm_data;
    logic w_unused;
    assign w_unused = ^{w_ocb[7:3], w_attr[7]};

    // 9-bit difference: objects near the bottom never wrap onto the top lines
    logic [8:0] w_dy;
    assign w_dy = {1'b0, r_y} - {1'b0, w_oy};

    logic       w_eval, w_hit, w_full, w_take, w_scan_end, w_fetch_rsp, w_fetch_end;
    logic [2:0] w_row;
    assign w_eval      = (r_state == SCAN) && (r_cnt != '0);
    assign w_hit       = w_eval && (w_dy < 9'd8);
    assign w_full      = (r_nfill == SW'(SLOTS));
    assign w_take      = w_hit && !w_full;
    assign w_row       = w_attr[5] ? (3'd7 - w_dy[2:0]) : w_dy[2:0];
    assign w_scan_end  = (r_state == SCAN) && (r_cnt == CW'(NUM_OBJECTS));
    assign w_fetch_rsp = (r_state == FETCH) && (r_cnt != '0);
    assign w_fetch_end = (r_state == FETCH) && (r_cnt == CW'(r_nfill));

    function automatic logic [15:0] hrev(input logic [15:0] d);
        for (int i = 0; i < 8; i++) hrev[15-2*i -: 2] = d[2*i+1 -: 2];
    endfunction

    always_ff @(posedge i_clk_12_5875) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        if (i_line_start) w_nstate = SCAN;
        else begin
            case (r_state)
                SCAN:    if (w_scan_end) w_nstate = ((r_nfill == '0) && !w_take) ? DONE : FETCH;
                FETCH:   if (w_fetch_end) w_nstate = DONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_obm_addr = '0;
        o_pmf_addr = '0;
        if ((r_state == SCAN) && (r_cnt < CW'(NUM_OBJECTS))) o_obm_addr = 6'(r_cnt);
        if ((r_state == FETCH) && (r_cnt < CW'(r_nfill))) begin
            for (int k = 0; k < SLOTS; k++)
                if (r_cnt == CW'(k)) o_pmf_addr = {r_ppmfa[k], r_prow[k]};
        end
    end

    always_ff @(posedge i_clk_12_5875) begin
        if (!i_rst_n) begin
            r_cnt <= '0; r_y <= '0; r_nfill <= '0; r_povf <= 1'b0;
            r_px <= '0; r_pcol <= '0; r_phf <= '0; r_prow <= '0; r_ppmfa <= '0;
            r_ppat <= '0; r_pfet <= '0;
            r_ax <= '0; r_acol <= '0; r_apat <= '0; r_avld <= '0;
            o_overflow <= 1'b0; o_late <= 1'b0;
        end else if (i_line_start) begin
            // slots whose row never arrived go live as empty
            r_ax   <= r_px;
            r_acol <= r_pcol;
            r_apat <= r_ppat;
            r_avld <= r_pfet;
            o_overflow <= r_povf;
            o_late     <= (r_state == SCAN) || (r_state == FETCH);
            r_pfet  <= '0;
            r_nfill <= '0;
            r_povf  <= 1'b0;
            r_y     <= i_next_y;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SCAN: begin
                    r_cnt <= w_scan_end ? '0 : r_cnt + 1'b1;
                    if (w_hit && w_full) r_povf <= 1'b1;
                    if (w_take) begin
                        for (int k = 0; k < SLOTS; k++) begin
                            if (r_nfill == SW'(k)) begin
                                r_px[k]    <= w_ox;
                                r_pcol[k]  <= w_ocb[2:0];
                                r_phf[k]   <= w_attr[6];
                                r_prow[k]  <= w_row;
                                r_ppmfa[k] <= w_attr[4:0];
                            end
                        end
                        r_nfill <= r_nfill + 1'b1;
                    end
                end
                FETCH: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_fetch_rsp) begin
                        for (int k = 0; k < SLOTS; k++) begin
                            if (r_cnt == CW'(k + 1)) begin
                                r_ppat[k] <= r_phf[k] ? hrev(i_pmf_data) : i_pmf_data;
                                r_pfet[k] <= 1'b1;
                            end
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // render: per-slot coverage and pixel, then lowest slot wins
    logic [SLOTS-1:0]      w_cov;
    logic [SLOTS-1:0][1:0] w_pix;
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        logic [2:0] w_off;
        assign w_off    = i_current_x[2:0] - r_ax[k][2:0];
        assign w_cov[k] = r_avld[k] && (i_current_x >= r_ax[k]) &&
                          ({1'b0, i_current_x} < ({1'b0, r_ax[k]} + 9'd8));
        // pixel i sits at bits [15-2i -: 2]; 15-2i == {~i,1}
        assign w_pix[k] = r_apat[k][{~w_off, 1'b1} -: 2];
    end

    logic [1:0] w_sel_p;
    logic [2:0] w_sel_c;
    logic       w_sel_v;
    always_comb begin
        w_sel_p = '0;
        w_sel_c = '0;
        w_sel_v = 1'b0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (w_cov[k] && (w_pix[k] != 2'b00)) begin
                w_sel_p = w_pix[k];
                w_sel_c = r_acol[k];
                w_sel_v = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_12_5875) begin
        if (!i_rst_n) begin
            o_r <= '0; o_g <= '0; o_b <= '0; o_valid <= 1'b0;
        end else begin
            o_r     <= w_sel_p & {2{w_sel_c[2]}};
            o_g     <= w_sel_p & {2{w_sel_c[1]}};
            o_b     <= w_sel_p & {2{w_sel_c[0]}};
            o_valid <= w_sel_v;
        end
    end
endmodule

// File: tb/tb_sprite_line_engine.sv
// Bench for sprite_line_engine: directed lines against a per-line model that
// snapshots the hit list at line_start and decides at the next line_start, from
// elapsed cycles, how much of the preparation completed.
module tb_sprite_line_engine;
    localparam int N = 64;
    localparam int S = 8;

    logic clk = 1'b0, rst_n = 1'b0, line_start = 1'b0;
    logic [7:0]  next_y = '0, current_x = '0;
    logic [5:0]  obm_addr;
    logic [31:0] obm_data;
    logic [7:0]  pmf_addr;
    logic [15:0] pmf_data;
    logic [1:0]  r, g, b;
    logic        valid, overflow, late;

    logic [31:0] obm [64];
    logic [15:0] pmf [256];
    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sprite_line_engine #(.NUM_OBJECTS(N), .SLOTS(S)) dut (
        .i_clk_12_5875(clk), .i_rst_n(rst_n), .i_line_start(line_start),
        .i_next_y(next_y), .i_current_x(current_x),
        .o_obm_addr(obm_addr), .i_obm_data(obm_data),
        .o_pmf_addr(pmf_addr), .i_pmf_data(pmf_data),
        .o_r(r), .o_g(g), .o_b(b), .o_valid(valid),
        .o_overflow(overflow), .o_late(late)
    );

    always @(posedge clk) begin
        obm_data <= obm[obm_addr];
        pmf_data <= pmf[pmf_addr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          p_n, p_idx [64];
    logic [7:0]  p_x [64];
    logic [2:0]  p_c [64];
    logic [15:0] p_pat [64];
    bit          have_prep;
    int          ls_cyc, cyc = 0;
    bit          a_v [S];
    logic [7:0]  a_x [S];
    logic [2:0]  a_c [S];
    logic [15:0] a_pat [S];
    logic [1:0]  e_r, e_g, e_b;
    logic        e_v, e_ovf, e_late;
    int          d_m, ev_m, n_m, off_m;
    logic [31:0] w_m;
    logic [8:0]  dy_m;
    logic [2:0]  row_m;
    logic [15:0] raw_m, pat_m;
    logic [1:0]  p_m;
    bit          found_m, ov_m, lt_m;

    always @(posedge clk) begin
        if (!rst_n) begin
            have_prep = 1'b0;
            for (int k = 0; k < S; k++) a_v[k] = 1'b0;
            {e_r, e_g, e_b, e_v, e_ovf, e_late} = '0;
        end else begin
            {e_r, e_g, e_b, e_v} = '0;
            found_m = 1'b0;
            for (int k = 0; k < S; k++) begin
                if (!found_m && a_v[k] && current_x >= a_x[k] && int'(current_x) < int'(a_x[k]) + 8) begin
                    off_m = int'(current_x) - int'(a_x[k]);
                    p_m = a_pat[k][15-2*off_m -: 2];
                    if (p_m != 2'b00) begin
                        e_r = p_m & {2{a_c[k][2]}};
                        e_g = p_m & {2{a_c[k][1]}};
                        e_b = p_m & {2{a_c[k][0]}};
                        e_v = 1'b1;
                        found_m = 1'b1;
                    end
                end
            end
            if (line_start) begin
                for (int k = 0; k < S; k++) a_v[k] = 1'b0;
                ov_m = 1'b0; lt_m = 1'b0;
                if (have_prep) begin
                    d_m = cyc - ls_cyc;
                    ev_m = 0;
                    for (int i = 0; i < p_n; i++) if (p_idx[i] + 2 < d_m) ev_m++;
                    ov_m = (ev_m > S);
                    if (d_m <= N + 1) lt_m = 1'b1;
                    else begin
                        n_m = (p_n < S) ? p_n : S;
                        lt_m = (n_m > 0) && (d_m <= N + n_m + 2);
                        for (int j = 0; j < n_m; j++) begin
                            if (j < d_m - N - 3) begin
                                a_v[j] = 1'b1; a_x[j] = p_x[j]; a_c[j] = p_c[j]; a_pat[j] = p_pat[j];
                            end
                        end
                    end
                end
                e_ovf = ov_m;
                e_late = lt_m;
                p_n = 0;
                for (int i = 0; i < N; i++) begin
                    w_m = obm[i];
                    dy_m = {1'b0, next_y} - {1'b0, w_m[23:16]};
                    if (dy_m < 9'd8) begin
                        row_m = w_m[13] ? (3'd7 - dy_m[2:0]) : dy_m[2:0];
                        raw_m = pmf[{w_m[12:8], row_m}];
                        pat_m = raw_m;
                        if (w_m[14])
                            for (int q = 0; q < 8; q++) pat_m[15-2*q -: 2] = raw_m[15-2*(7-q) -: 2];
                        p_idx[p_n] = i; p_x[p_n] = w_m[31:24]; p_c[p_n] = w_m[2:0]; p_pat[p_n] = pat_m;
                        p_n++;
                    end
                end
                have_prep = 1'b1;
                ls_cyc = cyc;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en)
            check("stream", 32'({r, g, b, valid, overflow, late}),
                            32'({e_r, e_g, e_b, e_v, e_ovf, e_late}));
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        for (int i = 0; i < 64; i++) obm[i] = 32'h00FF_0000;
        for (int i = 0; i < 256; i++) pmf[i] = 16'h0000;
    endtask

    task automatic pulse(input logic [7:0] ny);
        next_y = ny; line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            current_x = current_x + 8'd3;
            @(negedge clk);
        end
    endtask

    task automatic px(input string nm, input logic [7:0] cx, input logic [6:0] exp);
        current_x = cx;
        @(negedge clk);
        check(nm, 32'({r, g, b, valid}), 32'(exp));
    endtask

    bit seen;

    initial begin
        clr();
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset", 32'({r, g, b, valid, overflow, late, obm_addr, pmf_addr}), 32'd0);
        rst_n = 1'b1;
        run(4);

        // single object
        obm[0] = 32'h1020_0304; pmf[24] = 16'hC000;
        pulse(8'h20); run(90);
        pulse(8'h21);
        px("single_on",  8'h10, {2'd3, 2'd0, 2'd0, 1'b1});
        px("single_off", 8'h11, 7'd0);
        run(90);

        // priority
        clr();
        obm[2] = 32'h5020_0501; obm[5] = 32'h5220_0602;
        pmf[40] = 16'hFFFF; pmf[48] = 16'hAAAA;
        pulse(8'h20); run(90);
        pulse(8'h20);
        px("prio_obj2", 8'h53, {2'd0, 2'd0, 2'd3, 1'b1});
        run(90);
        pmf[40] = 16'hFCFF;
        pulse(8'h20); run(90);
        pulse(8'h20);
        px("prio_obj5", 8'h53, {2'd0, 2'd2, 2'd0, 1'b1});
        run(90);

        // overflow
        clr();
        for (int i = 0; i < 10; i++) obm[i] = {8'(i * 16), 8'h40, 8'h01, 8'h07};
        pmf[8] = 16'hFFFF;
        pulse(8'h40); run(90);
        pulse(8'h50);
        check("ovf_set", 32'(overflow), 32'd1);
        px("ovf_obj7", 8'h70, {2'd3, 2'd3, 2'd3, 1'b1});
        px("ovf_obj8", 8'h85, 7'd0);
        px("ovf_obj9", 8'h95, 7'd0);
        run(90);
        pulse(8'h50);
        check("ovf_clr", 32'(overflow), 32'd0);
        run(90);

        // flips
        clr();
        obm[0] = 32'h2030_6202; pmf[23] = 16'h0003;
        pulse(8'h30);
        seen = 1'b0;
        for (int i = 0; i < 90; i++) begin
            if (!seen && pmf_addr != 8'h00) begin
                seen = 1'b1;
                check("flip_addr", 32'(pmf_addr), 32'h17);
            end
            @(negedge clk);
        end
        if (!seen) check("flip_addr_seen", 32'd0, 32'd1);
        pulse(8'h31);
        px("flip_x0", 8'h20, {2'd0, 2'd3, 2'd0, 1'b1});
        px("flip_x7", 8'h27, 7'd0);
        run(90);

        // horizontal / vertical edges
        clr();
        obm[0] = 32'hFC60_0401; obm[1] = 32'h00FA_0401; pmf[32] = 16'hFFFF;
        pulse(8'h60); run(90);
        pulse(8'h01);
        px("edge_fc", 8'hFC, {2'd0, 2'd0, 2'd3, 1'b1});
        px("edge_ff", 8'hFF, {2'd0, 2'd0, 2'd3, 1'b1});
        px("edge_00", 8'h00, 7'd0);
        px("edge_03", 8'h03, 7'd0);
        run(90);
        pulse(8'h60);
        px("clip_bottom", 8'h02, 7'd0);
        run(90);

        // late line_start
        clr();
        for (int i = 0; i < 3; i++) obm[i] = {8'(8'h10 + i * 16), 8'h70, 8'h01, 8'h07};
        pmf[8] = 16'hFFFF;
        pulse(8'h70); run(19);
        pulse(8'h70);
        check("late_set", 32'(late), 32'd1);
        px("late_empty", 8'h10, 7'd0);
        run(90);
        pulse(8'h70);
        check("late_clr", 32'(late), 32'd0);
        px("late_recover", 8'h10, {2'd3, 2'd3, 2'd3, 1'b1});

        // reset mid-FETCH
        run(90);
        pulse(8'h70); run(66);
        current_x = 8'h10; rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid", 32'({valid, obm_addr, pmf_addr}), 32'd0);
        rst_n = 1'b1;
        run(5);
        pulse(8'h70);
        check("late_after_rst", 32'(late), 32'd0);
        px("bank_empty_rst", 8'h10, 7'd0);
        run(90);
        pulse(8'h70);
        px("after_rst_show", 8'h10, {2'd3, 2'd3, 2'd3, 1'b1});
        run(10);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
